// File: rtl/hsv_to_rgb_if.sv
// HSV-in / RGB-out valid-ready stream bundle shared by the converter and its neighbours.
interface hsv_to_rgb_if #(
    parameter int unsigned DATA_W = 8
);
    logic [24:0]       H;
    logic [17:0]       S;
    logic [17:0]       V;
    logic              IN_VALID;
    logic              IN_READY;
    logic [DATA_W-1:0] R;
    logic [DATA_W-1:0] G;
    logic [DATA_W-1:0] B;
    logic              OUT_VALID;
    logic              OUT_READY;

    // Producer/consumer side: drives HSV and downstream ready, observes RGB.
    modport master (
        output H, S, V, IN_VALID, OUT_READY,
        input  IN_READY, R, G, B, OUT_VALID
    );

    // Converter side.
    modport slave (
        input  H, S, V, IN_VALID, OUT_READY,
        output IN_READY, R, G, B, OUT_VALID
    );
endinterface

// File: rtl/hsv_to_rgb.sv
// Five-stage HSV (9.16 / 2.16 / 2.16 fixed point) to DATA_W-bit RGB converter.
// A single stall enable freezes every stage while the output is held.
module hsv_to_rgb #(
    parameter int unsigned DATA_W = 8
) (
    input logic         CLK,
    input logic         RST,
    hsv_to_rgb_if.slave bus
);
    localparam int unsigned SCW = DATA_W + 18;   // scaling product + rounding
    localparam int unsigned HIW = DATA_W + 2;    // scaled result before saturation
    localparam logic [24:0] HUE_FULL = 25'h1680000;
    localparam logic [24:0] SEC_W    = 25'h03C0000;
    localparam logic [16:0] ONE      = 17'h10000;
    localparam logic [16:0] FRAC_K   = 17'd69905; // ~2^22/60: sector remainder -> 0.16 fraction
    localparam logic [DATA_W-1:0] CMAX = '1;

    logic ce;

    logic        s1_vld, s2_vld, s3_vld, s4_vld;
    logic [2:0]  s1_sec, s2_sec, s3_sec;
    logic [21:0] s1_rem;
    logic [16:0] s1_s, s1_v, s2_s, s2_v, s3_s, s3_v;
    logic [15:0] s2_f, s3_sf;
    logic [16:0] s2_p, s3_p;
    logic [16:0] s4_r, s4_g, s4_b;

    logic [24:0] h_c;
    logic [16:0] s_c, v_c;
    logic [2:0]  sec_c;
    logic [21:0] rem_c;
    logic [38:0] fprod_c;
    logic [16:0] fsh_c;
    logic [15:0] f_c;
    logic [16:0] p_c;
    logic [15:0] sf_c;
    logic [17:0] top_c;
    logic [16:0] q_c, t_c;
    logic [16:0] r_c, g_c, b_c;

    // Round x/0x10000 onto the 0..2^DATA_W-1 output scale, saturating at full scale.
    function automatic logic [DATA_W-1:0] scale(input logic [16:0] x);
        logic [SCW-1:0] acc;
        logic [HIW-1:0] hi;
        acc   = SCW'(x) * SCW'(CMAX) + SCW'(32'h8000);
        hi    = HIW'(acc >> 16);
        scale = (hi > HIW'(CMAX)) ? CMAX : hi[DATA_W-1:0];
    endfunction

    // Pipeline advances whenever the output register is empty or being drained.
    assign ce           = bus.OUT_READY | ~bus.OUT_VALID;
    assign bus.IN_READY = ce;

    // Stage 1 logic: clamp inputs, locate the 60-degree sector and the offset inside it.
    always_comb begin
        h_c   = (bus.H >= HUE_FULL) ? bus.H - HUE_FULL : bus.H;
        s_c   = (bus.S > 18'(ONE)) ? ONE : bus.S[16:0];
        v_c   = (bus.V > 18'(ONE)) ? ONE : bus.V[16:0];
        sec_c = 3'(h_c >= 25'h03C0000) + 3'(h_c >= 25'h0780000) + 3'(h_c >= 25'h0B40000)
              + 3'(h_c >= 25'h0F00000) + 3'(h_c >= 25'h12C0000);
        rem_c = 22'(h_c - SEC_W * 25'(sec_c));
    end

    // Stage 2-4 logic: sector fraction, p/q/t terms and per-sector channel selection.
    always_comb begin
        fprod_c = 39'(s1_rem) * 39'(FRAC_K);
        fsh_c   = 17'(fprod_c >> 22);
        f_c     = (fsh_c > 17'h0FFFF) ? 16'hFFFF : fsh_c[15:0];
        p_c     = 17'((34'(s1_v) * 34'(ONE - s1_s)) >> 16);
        sf_c    = 16'((33'(s2_s) * 33'(s2_f)) >> 16);
        top_c   = 18'(ONE) - 18'(s3_s) + 18'(s3_sf);
        q_c     = 17'((34'(s3_v) * 34'(ONE - 17'(s3_sf))) >> 16);
        t_c     = 17'((35'(s3_v) * 35'(top_c)) >> 16);
        r_c     = s3_v;
        g_c     = s3_p;
        b_c     = q_c;
        case (s3_sec)
            3'd0:    begin r_c = s3_v; g_c = t_c;  b_c = s3_p; end
            3'd1:    begin r_c = q_c;  g_c = s3_v; b_c = s3_p; end
            3'd2:    begin r_c = s3_p; g_c = s3_v; b_c = t_c;  end
            3'd3:    begin r_c = s3_p; g_c = q_c;  b_c = s3_v; end
            3'd4:    begin r_c = t_c;  g_c = s3_p; b_c = s3_v; end
            default: begin r_c = s3_v; g_c = s3_p; b_c = q_c;  end
        endcase
    end

    // Stage registers, all frozen together when ce is low; reset clears every stage.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            s1_vld <= 1'b0; s1_sec <= '0; s1_rem <= '0; s1_s <= '0; s1_v <= '0;
            s2_vld <= 1'b0; s2_sec <= '0; s2_f <= '0; s2_p <= '0; s2_s <= '0; s2_v <= '0;
            s3_vld <= 1'b0; s3_sec <= '0; s3_sf <= '0; s3_p <= '0; s3_s <= '0; s3_v <= '0;
            s4_vld <= 1'b0; s4_r <= '0; s4_g <= '0; s4_b <= '0;
            bus.OUT_VALID <= 1'b0;
            bus.R <= '0;
            bus.G <= '0;
            bus.B <= '0;
        end else if (ce) begin
            s1_vld <= bus.IN_VALID; s1_sec <= sec_c; s1_rem <= rem_c;
            s1_s   <= s_c;          s1_v   <= v_c;
            s2_vld <= s1_vld; s2_sec <= s1_sec; s2_f <= f_c; s2_p <= p_c;
            s2_s   <= s1_s;   s2_v   <= s1_v;
            s3_vld <= s2_vld; s3_sec <= s2_sec; s3_sf <= sf_c; s3_p <= s2_p;
            s3_s   <= s2_s;   s3_v   <= s2_v;
            s4_vld <= s3_vld; s4_r <= r_c; s4_g <= g_c; s4_b <= b_c;
            bus.OUT_VALID <= s4_vld;
            bus.R <= scale(s4_r);
            bus.G <= scale(s4_g);
            bus.B <= scale(s4_b);
        end
    end
endmodule

// File: tb/tb_hsv_to_rgb.sv
// Directed and reference-model checks for the HSV->RGB pipeline (DATA_W = 8).
module tb_hsv_to_rgb;
    logic CLK;
    logic RST;
    int   vectors;
    int   miscompares;
    logic [23:0] exp_q[$];

    hsv_to_rgb_if #(.DATA_W(8)) bus();

    hsv_to_rgb #(.DATA_W(8)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Bit-exact model of the conversion formulas, written in plain integer arithmetic.
    function automatic logic [23:0] ref_rgb(input logic [24:0] h, input logic [17:0] s,
                                            input logic [17:0] v);
        longint hh, ss, vv, rem, sec, f, p, sf, q, t, x, y;
        longint ch [3];
        logic [23:0] res;
        hh = longint'(h); ss = longint'(s); vv = longint'(v);
        if (ss > 65536) ss = 65536;
        if (vv > 65536) vv = 65536;
        if (hh >= 23592960) hh = hh - 23592960;
        sec = 0; rem = hh;
        while (rem >= 3932160) begin rem = rem - 3932160; sec = sec + 1; end
        f  = (rem * 69905) / 4194304;
        if (f > 65535) f = 65535;
        p  = (vv * (65536 - ss)) / 65536;
        sf = (ss * f) / 65536;
        q  = (vv * (65536 - sf)) / 65536;
        t  = (vv * (65536 - ss + sf)) / 65536;
        case (sec)
            0: ch = '{vv, t, p};
            1: ch = '{q, vv, p};
            2: ch = '{p, vv, t};
            3: ch = '{p, q, vv};
            4: ch = '{t, p, vv};
            default: ch = '{vv, p, q};
        endcase
        res = '0;
        for (int i = 0; i < 3; i++) begin
            x = ch[i];
            y = (x * 255 + 32768) / 65536;
            if (y > 255) y = 255;
            res = (res << 8) | 24'(y);
        end
        return res;
    endfunction

    // Send one pixel into an idle pipeline and return its colour and latency (-1 on timeout).
    task automatic apply_one(input logic [24:0] h, input logic [17:0] s, input logic [17:0] v,
                             output logic [23:0] rgb, output int lat);
        lat = -1;
        rgb = '0;
        @(negedge CLK);
        bus.OUT_READY = 1'b1;
        bus.H = h; bus.S = s; bus.V = v; bus.IN_VALID = 1'b1;
        @(posedge CLK);
        for (int c = 1; c <= 20 && lat < 0; c++) begin
            @(negedge CLK);
            bus.IN_VALID = 1'b0;
            if (bus.OUT_VALID) begin
                lat = c;
                rgb = {bus.R, bus.G, bus.B};
            end
        end
    endtask

    task automatic test_reset();
        @(negedge CLK); #1;
        vectors++;
        if (bus.OUT_VALID !== 1'b0) begin
            miscompares++; $display("FAIL reset_out_valid: got %b expected 0", bus.OUT_VALID);
        end
        vectors++;
        if ({bus.R, bus.G, bus.B} !== 24'h000000) begin
            miscompares++; $display("FAIL reset_rgb: got %h expected 000000", {bus.R, bus.G, bus.B});
        end
        vectors++;
        if (bus.IN_READY !== 1'b1) begin
            miscompares++; $display("FAIL reset_in_ready: got %b expected 1", bus.IN_READY);
        end
        @(negedge CLK);
        RST = 1'b0;
    endtask

    task automatic test_primaries();
        logic [24:0] hv [3] = '{25'h0000000, 25'h0780000, 25'h0F00000};
        logic [23:0] ev [3] = '{24'hFF0000, 24'h00FF00, 24'h0000FF};
        logic [23:0] rgb;
        int lat;
        for (int i = 0; i < 3; i++) begin
            apply_one(hv[i], 18'h10000, 18'h10000, rgb, lat);
            vectors++;
            if (rgb !== ev[i]) begin
                miscompares++; $display("FAIL primary_%0d: got %h expected %h", i, rgb, ev[i]);
            end
            vectors++;
            if (lat !== 5) begin
                miscompares++; $display("FAIL primary_latency_%0d: got %0d expected 5", i, lat);
            end
        end
    endtask

    // 30 degrees lands just below half because 69905 slightly undershoots 2^22/60.
    task automatic test_secondaries();
        logic [24:0] hv [3] = '{25'h03C0000, 25'h01E0000, 25'h1680000};
        logic [23:0] ev [3] = '{24'hFFFF00, 24'hFF7F00, 24'hFF0000};
        logic [23:0] rgb;
        int lat;
        for (int i = 0; i < 3; i++) begin
            apply_one(hv[i], 18'h10000, 18'h10000, rgb, lat);
            vectors++;
            if (rgb !== ev[i]) begin
                miscompares++; $display("FAIL secondary_%0d: got %h expected %h", i, rgb, ev[i]);
            end
        end
    endtask

    task automatic test_grey_clamp();
        logic [24:0] hv [6] = '{25'h0000000, 25'h09A1234, 25'h1500000, 25'h0500000,
                                25'h0780000, 25'h01E0000};
        logic [17:0] sv [6] = '{18'h00000, 18'h00000, 18'h00000, 18'h10000, 18'h3FFFF, 18'h3FFFF};
        logic [17:0] vv [6] = '{18'h08000, 18'h08000, 18'h08000, 18'h00000, 18'h3FFFF, 18'h3FFFF};
        logic [23:0] ev [6] = '{24'h808080, 24'h808080, 24'h808080, 24'h000000,
                                24'h00FF00, 24'hFF7F00};
        logic [23:0] rgb;
        int lat;
        for (int i = 0; i < 6; i++) begin
            apply_one(hv[i], sv[i], vv[i], rgb, lat);
            vectors++;
            if (rgb !== ev[i]) begin
                miscompares++; $display("FAIL grey_clamp_%0d: got %h expected %h", i, rgb, ev[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [24:0] hv [10] = '{25'h0000000, 25'h03C0000, 25'h0780000, 25'h0B40000, 25'h0F00000,
                                 25'h12C0000, 25'h0123456, 25'h0400000, 25'h1680000, 25'h01E0000};
        logic [17:0] sv [10] = '{18'h10000, 18'h10000, 18'h10000, 18'h10000, 18'h10000,
                                 18'h10000, 18'h00000, 18'h10000, 18'h10000, 18'h10000};
        logic [17:0] vv [10] = '{18'h10000, 18'h10000, 18'h10000, 18'h10000, 18'h10000,
                                 18'h10000, 18'h08000, 18'h00000, 18'h10000, 18'h10000};
        logic [23:0] ev [10] = '{24'hFF0000, 24'hFFFF00, 24'h00FF00, 24'h00FFFF, 24'h0000FF,
                                 24'hFF00FF, 24'h808080, 24'h000000, 24'hFF0000, 24'hFF7F00};
        int sent = 0;
        int got = 0;
        int stall_left = 0;
        int stall_seen = 0;
        bit stalled_once = 1'b0;
        bit held_pending = 1'b0;
        bit acc;
        logic [24:0] held;
        fork
            begin
                for (int c = 0; c < 200 && sent < 10; c++) begin
                    @(negedge CLK);
                    bus.IN_VALID = 1'b1;
                    bus.H = hv[sent]; bus.S = sv[sent]; bus.V = vv[sent];
                    #2;
                    acc = bus.IN_READY;
                    @(posedge CLK);
                    if (acc) sent++;
                end
                @(negedge CLK);
                bus.IN_VALID = 1'b0;
            end
            begin
                for (int c = 0; c < 200 && got < 10; c++) begin
                    @(negedge CLK);
                    if (stall_left > 0) begin
                        bus.OUT_READY = 1'b0;
                        stall_left--;
                    end else begin
                        bus.OUT_READY = 1'b1;
                    end
                    #1;
                    if (held_pending) begin
                        vectors++;
                        if ({bus.OUT_VALID, bus.R, bus.G, bus.B} !== held) begin
                            miscompares++;
                            $display("FAIL b2b_hold: got %h expected %h",
                                     {bus.OUT_VALID, bus.R, bus.G, bus.B}, held);
                        end
                    end
                    if (!bus.OUT_READY) begin
                        stall_seen++;
                        vectors++;
                        if (bus.IN_READY !== 1'b0) begin
                            miscompares++;
                            $display("FAIL b2b_in_ready_stall: got %b expected 0", bus.IN_READY);
                        end
                    end
                    if (bus.OUT_VALID && bus.OUT_READY) begin
                        vectors++;
                        if ({bus.R, bus.G, bus.B} !== ev[got]) begin
                            miscompares++;
                            $display("FAIL b2b_pixel_%0d: got %h expected %h", got,
                                     {bus.R, bus.G, bus.B}, ev[got]);
                        end
                        got++;
                        if (got == 3 && !stalled_once) begin
                            stall_left = 3;
                            stalled_once = 1'b1;
                        end
                    end
                    held_pending = bus.OUT_VALID && !bus.OUT_READY;
                    held = {bus.OUT_VALID, bus.R, bus.G, bus.B};
                end
            end
        join
        vectors++;
        if (got !== 10) begin
            miscompares++; $display("FAIL b2b_count: got %0d expected 10", got);
        end
        vectors++;
        if (stall_seen !== 3) begin
            miscompares++; $display("FAIL b2b_stall_cycles: got %0d expected 3", stall_seen);
        end
        repeat (8) @(negedge CLK);
    endtask

    task automatic test_reset_midstream();
        logic [24:0] hv [5] = '{25'h0780000, 25'h0000000, 25'h0F00000, 25'h03C0000, 25'h0B40000};
        int stale = 0;
        logic [23:0] rgb;
        int lat;
        @(negedge CLK);
        bus.OUT_READY = 1'b0;
        for (int i = 0; i < 5; i++) begin
            bus.IN_VALID = 1'b1;
            bus.H = hv[i]; bus.S = 18'h10000; bus.V = 18'h10000;
            @(negedge CLK);
        end
        bus.IN_VALID = 1'b0;
        #1;
        vectors++;
        if ({bus.OUT_VALID, bus.R, bus.G, bus.B} !== {1'b1, 24'h00FF00}) begin
            miscompares++;
            $display("FAIL rst_pre_state: got %h expected %h",
                     {bus.OUT_VALID, bus.R, bus.G, bus.B}, {1'b1, 24'h00FF00});
        end
        RST = 1'b1;
        #1;
        vectors++;
        if (bus.OUT_VALID !== 1'b0) begin
            miscompares++; $display("FAIL rst_async_valid: got %b expected 0", bus.OUT_VALID);
        end
        vectors++;
        if ({bus.R, bus.G, bus.B} !== 24'h000000) begin
            miscompares++; $display("FAIL rst_async_rgb: got %h expected 000000", {bus.R, bus.G, bus.B});
        end
        vectors++;
        if (bus.IN_READY !== 1'b1) begin
            miscompares++; $display("FAIL rst_in_ready: got %b expected 1", bus.IN_READY);
        end
        repeat (2) @(negedge CLK);
        RST = 1'b0;
        bus.OUT_READY = 1'b1;
        for (int c = 0; c < 12; c++) begin
            @(negedge CLK); #1;
            if (bus.OUT_VALID) stale++;
        end
        vectors++;
        if (stale !== 0) begin
            miscompares++; $display("FAIL rst_stale_outputs: got %0d expected 0", stale);
        end
        apply_one(25'h0F00000, 18'h10000, 18'h10000, rgb, lat);
        vectors++;
        if ({lat[7:0], rgb} !== {8'd5, 24'h0000FF}) begin
            miscompares++;
            $display("FAIL rst_first_pixel: got lat %0d rgb %h expected lat 5 rgb 0000ff", lat, rgb);
        end
    endtask

    task automatic test_random();
        int sent = 0;
        int got = 0;
        bit acc;
        logic [23:0] exp_v;
        exp_q.delete();
        fork
            begin
                for (int c = 0; c < 2000 && sent < 40; c++) begin
                    @(negedge CLK);
                    if (!bus.IN_VALID) begin
                        if ($urandom_range(0, 3) != 0) begin
                            bus.IN_VALID = 1'b1;
                            bus.H = 25'($urandom);
                            bus.S = ($urandom_range(0, 3) == 0) ? 18'($urandom)
                                                               : 18'($urandom_range(0, 65536));
                            bus.V = ($urandom_range(0, 3) == 0) ? 18'($urandom)
                                                               : 18'($urandom_range(0, 65536));
                        end
                    end
                    #2;
                    acc = bus.IN_VALID && bus.IN_READY;
                    @(posedge CLK);
                    if (acc) begin
                        exp_q.push_back(ref_rgb(bus.H, bus.S, bus.V));
                        sent++;
                        #1;
                        bus.IN_VALID = 1'b0;
                    end
                end
                @(negedge CLK);
                bus.IN_VALID = 1'b0;
            end
            begin
                for (int c = 0; c < 2000 && got < 40; c++) begin
                    @(negedge CLK);
                    bus.OUT_READY = ($urandom_range(0, 3) != 0);
                    #1;
                    if (bus.OUT_VALID && bus.OUT_READY) begin
                        vectors++;
                        if (exp_q.size() == 0) begin
                            miscompares++;
                            $display("FAIL rand_extra_%0d: got %h expected none", got,
                                     {bus.R, bus.G, bus.B});
                        end else begin
                            exp_v = exp_q.pop_front();
                            if ({bus.R, bus.G, bus.B} !== exp_v) begin
                                miscompares++;
                                $display("FAIL rand_pixel_%0d: got %h expected %h", got,
                                         {bus.R, bus.G, bus.B}, exp_v);
                            end
                        end
                        got++;
                    end
                end
            end
        join
        vectors++;
        if (got !== 40 || exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL rand_count: got %0d left %0d expected 40 left 0", got, exp_q.size());
        end
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        RST = 1'b1;
        bus.H = '0;
        bus.S = '0;
        bus.V = '0;
        bus.IN_VALID = 1'b0;
        bus.OUT_READY = 1'b1;
        repeat (2) @(negedge CLK);
        test_reset();
        test_primaries();
        test_secondaries();
        test_grey_clamp();
        test_back_to_back();
        test_reset_midstream();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
